// File: rtl/apb4_req_master.sv
// APB4 requester: turns a valid/ready command stream into single APB4 transfers, one outstanding.
// Define APB4_MST_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYC cycles.
module apb4_req_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  // state  | meaning
  // IDLE   | ready for a command
  // SETUP  | psel high, penable low, one cycle
  // ACCESS | psel and penable high, waiting on pready
  // RESP   | response held until consumed
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

`ifdef APB4_MST_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] access_cnt;
  logic             timed_out;
  // Counter holds completed wait cycles, so the last permitted ACCESS cycle sees TIMEOUT_CYC-1.
  assign timed_out = (access_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  assign pprot_o = 3'b000;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
      access_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            state       <= SETUP;
            req_ready_o <= 1'b0;
            psel_o      <= 1'b1;
            pwrite_o    <= req_write_i;
            paddr_o     <= req_addr_i;
            // Reads must present zero strobes and data on the bus.
            pwdata_o    <= req_write_i ? req_wdata_i : '0;
            pstrb_o     <= req_write_i ? req_strb_i : '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
`ifdef APB4_MST_TIMEOUT_EN
          access_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (pready_i) begin
            state       <= RESP;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
            rsp_err_o   <= pslverr_i;
          end
`ifdef APB4_MST_TIMEOUT_EN
          else if (timed_out) begin
            state       <= RESP;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
          end else begin
            access_cnt <= access_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          psel_o      <= 1'b0;
          penable_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_req_master.sv
// Randomized scoreboard bench for apb4_req_master with an APB4 completer model.
// Timeout expectations are included when APB4_MST_TIMEOUT_EN is defined.
module tb_apb4_req_master;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  apb4_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
    .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] prdata;
    logic        err;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;
  } txn_t;

  txn_t cfg_q[$];
  txn_t bus_q[$];
  txn_t rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: response content and ACCESS length from the protocol rules.
  function automatic void model(inout txn_t t);
    bit to = 1'b0;
    int acc;
`ifdef APB4_MST_TIMEOUT_EN
    to = (t.waits >= TO);
`endif
    if (to) begin
      t.exp_rd  = 32'h0;
      t.exp_err = 1'b1;
      acc       = TO;
    end else begin
      t.exp_rd  = t.wr ? 32'h0 : t.prdata;
      t.exp_err = t.err;
      acc       = t.waits + 1;
    end
    // handshake edge + 1 SETUP cycle + acc ACCESS cycles
    t.exp_cyc = cyc + 2 + acc;
  endfunction

  task automatic send(input txn_t t);
    int n = 0;
    req_valid = 1'b1;
    req_write = t.wr;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_strb  = t.strb;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", req_ready, 1'b1);
    if (req_ready) begin
      model(t);
      cfg_q.push_back(t);
      bus_q.push_back(t);
      rsp_q.push_back(t);
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_write = $urandom % 2;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_strb  = $urandom % 16;
  endtask

  function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int waits, input logic [31:0] prd,
                              input logic err, input int hold);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb; t.waits = waits;
    t.prdata = prd; t.err = err; t.hold = hold;
    t.exp_rd = 0; t.exp_err = 0; t.exp_cyc = 0;
    return t;
  endfunction

  // APB4 completer model: garbage on pready/prdata/pslverr outside the completing cycle.
  initial begin
    txn_t cur;
    int   left = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
    pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && psel === 1'b1 && penable === 1'b0) begin
        check("cfg_avail", cfg_q.size() != 0, 1'b1);
        if (cfg_q.size() != 0) cur = cfg_q.pop_front();
        left = cur.waits;
      end
      if (rst_n && psel === 1'b1 && penable === 1'b1 && left == 0) begin
        pready = 1'b1; prdata = cur.prdata; pslverr = cur.err;
      end else begin
        if (rst_n && psel === 1'b1 && penable === 1'b1) left--;
        pready  = (psel === 1'b1 && penable === 1'b1) ? 1'b0 : 1'($urandom % 2);
        prdata  = $urandom;
        pslverr = $urandom % 2;
      end
    end
  end

  // Bus monitor: SETUP contents and stability through ACCESS.
  initial begin
    txn_t b;
    b = mk(0, 0, 0, 0, 0, 0, 0, 0);
    forever begin
      @(negedge clk);
      if (rst_n && psel === 1'b1) begin
        if (penable === 1'b0) begin
          check("bus_avail", bus_q.size() != 0, 1'b1);
          if (bus_q.size() != 0) b = bus_q.pop_front();
          check("setup_req_ready", req_ready, 1'b0);
          check("pprot", pprot, 3'b000);
        end
        check("bus_fields", {paddr, pwrite, pwdata, pstrb},
              {b.addr, b.wr, (b.wr ? b.wdata : 32'h0), (b.wr ? b.strb : 4'h0)});
      end
    end
  end

  // Response monitor and rsp_ready driver.
  initial begin
    txn_t cur;
    bit   active = 1'b0;
    int   held = 0;
    logic [32:0] first;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
    first = '0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          held   = 0;
          check("rsp_avail", rsp_q.size() != 0, 1'b1);
          if (rsp_q.size() != 0) cur = rsp_q.pop_front();
          check("rsp_latency", cyc, cur.exp_cyc);
          check("rsp_data_err", {rsp_rdata, rsp_err}, {cur.exp_rd, cur.exp_err});
          first = {rsp_rdata, rsp_err};
        end else begin
          check("rsp_stable", {rsp_rdata, rsp_err}, first);
        end
        check("resp_req_ready", req_ready, 1'b0);
        check("resp_psel", {psel, penable}, 2'b00);
        rsp_ready = (held >= cur.hold);
        held++;
        if (rsp_ready) active = 1'b0;
      end else begin
        rsp_ready = $urandom % 2;
      end
    end
  end

  initial begin
    txn_t t;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 0; req_wdata = 0; req_strb = 0;
    repeat (3) @(negedge clk);
    check("rst_psel_pen", {psel, penable, pwrite}, 3'b000);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
    check("rst_bus", {paddr, pwdata, pstrb}, 68'h0);
    check("rst_req_ready", req_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    send(mk(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'hAAAA_5555, 0, 0));
    send(mk(0, 32'h1000_0008, 32'hFFFF_FFFF, 4'hF, 3, 32'h1234_5678, 0, 0));
    send(mk(1, 32'h2000_0010, 32'h0BAD_F00D, 4'h3, 1, 32'h0, 1, 0));
    send(mk(0, 32'h2000_0014, 32'h0, 4'h0, 0, 32'hCAFE_0001, 0, 0));
    send(mk(0, 32'h3000_0000, 32'h0, 4'h0, 2, 32'h5A5A_A5A5, 0, 5));
`ifdef APB4_MST_TIMEOUT_EN
    send(mk(0, 32'h4000_0000, 32'h0, 4'h0, 50, 32'h1111_2222, 0, 0));
`endif

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom % 3) @(negedge clk);
      send(mk($urandom % 2, $urandom, $urandom, $urandom % 16, $urandom_range(0, 5),
              $urandom, $urandom % 2, $urandom_range(0, 3)));
    end

    for (int i = 0; i < 200 && rsp_q.size() != 0; i++) @(negedge clk);
    check("drain1", rsp_q.size(), 0);
    repeat (3) @(negedge clk);

    // Reset during ACCESS: bus drops, no response, ready again after release.
    send(mk(0, 32'h5000_0000, 32'h0, 4'h0, 20, 32'h7777_7777, 0, 0));
    for (int i = 0; i < 10 && !(psel === 1'b1 && penable === 1'b1); i++) @(negedge clk);
    check("reached_access", {psel, penable}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bus", {psel, penable, rsp_valid}, 3'b000);
    rsp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {req_ready, psel, rsp_valid}, 3'b100);

    send(mk(1, 32'h6000_0000, 32'h1357_9BDF, 4'h5, 1, 32'h0, 0, 1));
    for (int i = 0; i < 200 && rsp_q.size() != 0; i++) @(negedge clk);
    check("drain2", rsp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
